// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction-fetch / data memory arbiter.
//   arb_state_t : arbiter FSM states (one transaction in flight at a time)
//   gnt_kind_t  : which side owns the current transaction
//   *_DEFAULT   : default read latency and data-burst limit
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_kind_t;

  localparam int unsigned MEM_LAT_DEFAULT  = 2;
  localparam int unsigned MAX_DATA_DEFAULT = 4;

  // Both MEM_LAT and MAX_DATA are limited to 1..15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between an instruction-fetch port and a
// load/store data port. One transaction at a time: IDLE (grant) -> ISSUE (mem_en) ->
// WAIT (reads only, MEM_LAT cycles) -> RESP (ack pulse) -> IDLE.
// Data wins over fetch, except that after MAX_DATA data grants made while a fetch
// was waiting, the fetch is served next.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   enable              low blocks new grants (in-flight accesses still finish)
//   if_req/if_addr      fetch request, held until if_ack; if_rdata valid with if_ack
//   d_req/d_wr/d_addr/  data request (d_wr=1 store), held until d_ack;
//   d_wdata             d_rdata valid with d_ack (0 for stores)
//   mem_en/mem_wr/      memory strobe (one cycle per access), write enable,
//   mem_addr/mem_wdata  address and write data (held between accesses)
//   mem_rdata           read data, valid MEM_LAT cycles after the mem_en cycle
//   stall               a request is pending and not being acked this cycle
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT  = MEM_LAT_DEFAULT,
  parameter int unsigned MAX_DATA = MAX_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  localparam logic [CNT_W-1:0] LatInit = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] MaxCnt  = CNT_W'(MAX_DATA);

  arb_state_t       state_q, state_d;
  gnt_kind_t        kind_q, kind_d;
  logic [31:0]      addr_q, addr_d;
  logic             wr_q, wr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] starv_q, starv_d;
  logic             fetch_wins;

  // Fetch is chosen when it is the only requester or when data has used up its burst.
  assign fetch_wins = if_req && (!d_req || (starv_q == MaxCnt));

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    lat_d   = lat_q;
    starv_d = starv_q;

    unique case (state_q)
      IDLE: begin
        if (enable && (if_req || d_req)) begin
          state_d = ISSUE;
          if (fetch_wins) begin
            kind_d  = GNT_IF;
            addr_d  = if_addr;
            wr_d    = 1'b0;
            wdata_d = '0;
            starv_d = '0;
          end else begin
            kind_d  = GNT_D;
            addr_d  = d_addr;
            wr_d    = d_wr;
            wdata_d = d_wdata;
            // Only data grants that overtake a waiting fetch count towards starvation.
            if (if_req) begin
              starv_d = (starv_q == MaxCnt) ? starv_q : starv_q + 1'b1;
            end else begin
              starv_d = '0;
            end
          end
        end
      end

      ISSUE: begin
        lat_d   = LatInit;
        state_d = wr_q ? RESP : WAIT;
      end

      WAIT: begin
        if (lat_q == CNT_W'(1)) begin
          rdata_d = mem_rdata;
          lat_d   = '0;
          state_d = RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      kind_q  <= GNT_IF;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      lat_q   <= '0;
      starv_q <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      lat_q   <= lat_d;
      starv_q <= starv_d;
    end
  end

  // Address and write data come straight from the latched request, so they only
  // change when a new grant is taken and otherwise hold the previous access.
  assign mem_en    = (state_q == ISSUE);
  assign mem_wr    = mem_en && wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_ack   = (state_q == RESP) && (kind_q == GNT_IF);
  assign d_ack    = (state_q == RESP) && (kind_q == GNT_D);
  assign if_rdata = if_ack ? rdata_q : '0;
  assign d_rdata  = (d_ack && !wr_q) ? rdata_q : '0;

  assign stall = (if_req && !if_ack) || (d_req && !d_ack);

  // A requester must keep its request up until it sees its ack.
  a_if_req_held : assert property (@(posedge clk) disable iff (reset)
    ((state_q != IDLE) && (kind_q == GNT_IF)) |-> if_req);

  a_d_req_held : assert property (@(posedge clk) disable iff (reset)
    ((state_q != IDLE) && (kind_q == GNT_D)) |-> d_req);

  a_ack_onehot : assert property (@(posedge clk) !(if_ack && d_ack));

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int LAT  = 2;
  localparam int MAXD = 4;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic        if_req, d_req, d_wr;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ack, d_ack, mem_en, mem_wr, stall;

  // Second build with MEM_LAT=1, fetch side only.
  logic        if_req1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_ack1, d_ack1, mem_en1, mem_wr1, stall1;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(LAT), .MAX_DATA(MAXD)) u_dut (
    .clk(clk), .reset(reset), .enable(enable),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  mem_arbiter #(.MEM_LAT(1), .MAX_DATA(MAXD)) u_dut_lat1 (
    .clk(clk), .reset(reset), .enable(enable),
    .if_req(if_req1), .if_addr(32'h0), .if_rdata(if_rdata1), .if_ack(if_ack1),
    .d_req(1'b0), .d_wr(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_rdata(d_rdata1), .d_ack(d_ack1),
    .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .stall(stall1)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Two memories: ref_mem belongs to the reference model, resp_mem answers the DUT.
  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] resp_mem [logic [31:0]];
  logic [31:0] rd_at    [int];
  logic [31:0] en_log   [$];

  function automatic logic [31:0] def_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : def_word(a);
  endfunction

  function automatic logic [31:0] resp_rd(input logic [31:0] a);
    return resp_mem.exists(a) ? resp_mem[a] : def_word(a);
  endfunction

  // Transaction-level reference model: a grant at cycle g puts one access on the
  // memory at g+1 and acks at g+2 (store) or g+LAT+2 (read); next grant from ack+1.
  bit          model_on = 0;
  bit          pend = 0;
  bit          p_is_d, p_wr;
  int          en_cyc, ack_cyc;
  int          free_at = 0;
  int          starv = 0;
  logic [31:0] p_rdata;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  bit          if_ack_seen = 0, d_ack_seen = 0;

  task automatic model_step();
    bit e_en, e_ia, e_da, ifw;
    e_en = pend && (cyc == en_cyc);
    e_ia = pend && (cyc == ack_cyc) && !p_is_d;
    e_da = pend && (cyc == ack_cyc) && p_is_d;
    check_eq("mem_en", 32'(mem_en), 32'(e_en));
    check_eq("mem_wr", 32'(mem_wr), 32'(e_en && p_wr));
    check_eq("mem_addr", mem_addr, last_addr);
    check_eq("mem_wdata", mem_wdata, last_wdata);
    check_eq("if_ack", 32'(if_ack), 32'(e_ia));
    check_eq("d_ack", 32'(d_ack), 32'(e_da));
    if (e_ia) check_eq("if_rdata", if_rdata, p_rdata);
    if (e_da) check_eq("d_rdata", d_rdata, p_wr ? 32'h0 : p_rdata);
    check_eq("stall", 32'(stall), 32'((if_req && !e_ia) || (d_req && !e_da)));
    if (pend && (cyc == ack_cyc)) pend = 0;

    if (reset) begin
      pend = 0; starv = 0; free_at = cyc + 1; last_addr = 0; last_wdata = 0;
    end else if (!pend && (cyc >= free_at) && enable && (if_req || d_req)) begin
      ifw    = if_req && (!d_req || (starv == MAXD));
      pend   = 1;
      en_cyc = cyc + 1;
      p_is_d = !ifw;
      if (ifw) begin
        starv = 0; p_wr = 0; last_addr = if_addr; last_wdata = 0;
        p_rdata = ref_rd(if_addr);
      end else begin
        starv = if_req ? ((starv < MAXD) ? starv + 1 : MAXD) : 0;
        p_wr = d_wr; last_addr = d_addr; last_wdata = d_wdata;
        if (d_wr) ref_mem[d_addr] = d_wdata;
        else p_rdata = ref_rd(d_addr);
      end
      ack_cyc = p_wr ? cyc + 2 : cyc + LAT + 2;
      free_at = ack_cyc + 1;
    end
  endtask

  // Memory responder, ack observation and model, all mid-cycle.
  always @(negedge clk) begin
    if (rd_at.exists(cyc)) begin
      mem_rdata = rd_at[cyc];
      rd_at.delete(cyc);
    end else begin
      mem_rdata = $urandom;
    end
    if (mem_en === 1'b1) begin
      en_log.push_back(mem_addr);
      if (mem_wr) resp_mem[mem_addr] = mem_wdata;
      else rd_at[cyc + LAT] = resp_rd(mem_addr);
    end
    if_ack_seen = if_ack;
    d_ack_seen  = d_ack;
    if (model_on) model_step();
    cyc++;
  end

  bit          rd1_pending = 0;
  logic [31:0] rd1_word;
  always @(negedge clk) begin
    mem_rdata1  = rd1_pending ? rd1_word : $urandom;
    rd1_pending = (mem_en1 === 1'b1);
    rd1_word    = def_word(mem_addr1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts at the negedge of the current (grant) cycle, k=0.
  task automatic run_txn(input bit is_d, output int ack_k, output int en_k, output int n_en,
                         output logic [31:0] rdata);
    ack_k = -1; en_k = -1; n_en = 0; rdata = 'x;
    for (int k = 0; k < 40 && ack_k < 0; k++) begin
      @(negedge clk);
      if (mem_en === 1'b1) begin
        n_en++;
        if (en_k < 0) en_k = k;
      end
      if ((is_d ? d_ack : if_ack) === 1'b1) begin
        ack_k = k;
        rdata = is_d ? d_rdata : if_rdata;
      end
    end
  endtask

  task automatic drop_all_after_ack();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (if_ack || d_ack) break;
    end
    tick();
    if_req = 0;
    d_req  = 0;
  endtask

  int          ack_k, en_k, n_en;
  logic [31:0] rdata;

  initial begin
    reset = 1; enable = 0; if_req = 0; if_addr = 0; d_req = 0; d_wr = 0;
    d_addr = 0; d_wdata = 0; if_req1 = 0;
    ref_mem[32'h40]  = 32'hDEAD_BEEF;
    resp_mem[32'h40] = 32'hDEAD_BEEF;
    tick();
    tick();
    model_on = 1;

    // Reset state
    @(negedge clk);
    check_eq("rst_mem_en", 32'(mem_en), 32'h0);
    check_eq("rst_mem_wr", 32'(mem_wr), 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    check_eq("rst_if_ack", 32'(if_ack), 32'h0);
    check_eq("rst_d_ack", 32'(d_ack), 32'h0);
    check_eq("rst_if_rdata", if_rdata, 32'h0);
    check_eq("rst_d_rdata", d_rdata, 32'h0);
    check_eq("rst_stall", 32'(stall), 32'h0);
    check_eq("rst_lat1_outs", {if_rdata1[29:0], if_ack1, d_ack1} | {mem_addr1[30:0], mem_en1},
             32'h0);
    tick();
    reset = 0; enable = 1;
    tick();

    // Single load
    d_req = 1; d_wr = 0; d_addr = 32'h40;
    run_txn(1, ack_k, en_k, n_en, rdata);
    check_eq("load_ack_cycle", ack_k, LAT + 2);
    check_eq("load_en_cycle", en_k, 1);
    check_eq("load_en_count", n_en, 1);
    check_eq("load_data", rdata, 32'hDEAD_BEEF);
    tick();
    d_req = 0;

    // Single store, then read it back
    d_req = 1; d_wr = 1; d_addr = 32'h80; d_wdata = 32'h1234_5678;
    run_txn(1, ack_k, en_k, n_en, rdata);
    check_eq("store_ack_cycle", ack_k, 2);
    check_eq("store_en_count", n_en, 1);
    check_eq("store_rdata_zero", rdata, 32'h0);
    tick();
    d_req = 0; d_wr = 0;
    @(negedge clk);
    check_eq("store_stall_after", 32'(stall), 32'h0);
    tick();
    d_req = 1; d_addr = 32'h80;
    run_txn(1, ack_k, en_k, n_en, rdata);
    check_eq("store_readback", rdata, 32'h1234_5678);
    tick();
    d_req = 0;

    // Contention: both held, starting from a cleared starvation count
    reset = 1;
    tick();
    reset = 0;
    en_log.delete();
    if_req = 1; if_addr = 32'h100; d_req = 1; d_wr = 0; d_addr = 32'h200;
    for (int k = 0; k < 200 && en_log.size() < 10; k++) @(negedge clk);
    check_eq("contention_grants", en_log.size(), 10);
    for (int i = 0; i < 10 && i < en_log.size(); i++)
      check_eq($sformatf("contention_order[%0d]", i), en_log[i],
               (i % 5 == 4) ? 32'h100 : 32'h200);
    drop_all_after_ack();

    // enable low blocks grants; data wins when it rises
    enable = 0; d_req = 1; d_wr = 0; d_addr = 32'h44; if_req = 1; if_addr = 32'h104;
    en_log.delete();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("disabled_mem_en", 32'(mem_en), 32'h0);
      check_eq("disabled_stall", 32'(stall), 32'h1);
    end
    tick();
    enable = 1;
    run_txn(1, ack_k, en_k, n_en, rdata);
    check_eq("enable_rise_ack", ack_k, LAT + 2);
    check_eq("enable_rise_first_addr", (en_log.size() > 0) ? en_log[0] : 32'hX, 32'h44);
    check_eq("enable_rise_data", rdata, ref_rd(32'h44));
    tick();
    d_req = 0;
    run_txn(0, ack_k, en_k, n_en, rdata);
    check_eq("fetch_after_data_ack", ack_k, LAT + 2);
    tick();
    if_req = 0;

    // Reset during a fetch's WAIT
    tick();
    if_req = 1; if_addr = 32'h10;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_en === 1'b1) break;
    end
    tick();
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    check_eq("abort_if_ack", 32'(if_ack), 32'h0);
    check_eq("abort_mem_en", 32'(mem_en), 32'h0);
    check_eq("abort_mem_addr", mem_addr, 32'h0);
    check_eq("abort_if_rdata", if_rdata, 32'h0);
    // The grant happened in the cycle just checked, so the ack is one negedge closer.
    run_txn(0, ack_k, en_k, n_en, rdata);
    check_eq("regrant_ack", ack_k, LAT + 1);
    check_eq("regrant_data", rdata, ref_rd(32'h10));
    tick();
    if_req = 0;

    // MEM_LAT=1 build: fetch of 0x0
    tick();
    if_req1 = 1;
    ack_k = -1;
    for (int k = 0; k < 20 && ack_k < 0; k++) begin
      @(negedge clk);
      if (if_ack1 === 1'b1) begin
        ack_k = k;
        rdata = if_rdata1;
      end
    end
    check_eq("lat1_ack_cycle", ack_k, 3);
    check_eq("lat1_data", rdata, def_word(32'h0));
    tick();
    if_req1 = 0;

    // Randomised traffic; no new requests near the end so everything drains
    for (int i = 0; i < 1600; i++) begin
      bit go;
      tick();
      go = (i < 1500);
      if (if_req) begin
        if (if_ack_seen) begin
          if_req = go && ($urandom_range(0, 1) == 1);
          if_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        end
      end else if (go && $urandom_range(0, 2) == 0) begin
        if_req = 1;
        if_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (d_req) begin
        if (d_ack_seen) begin
          d_req = go && ($urandom_range(0, 1) == 1);
          d_wr = 1'($urandom_range(0, 1));
          d_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
          d_wdata = $urandom;
        end
      end else if (go && $urandom_range(0, 1) == 0) begin
        d_req = 1;
        d_wr = 1'($urandom_range(0, 1));
        d_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        d_wdata = $urandom;
      end
      enable = go ? ($urandom_range(0, 7) != 0) : 1'b1;
      reset  = go && ($urandom_range(0, 299) == 0);
    end
    check_eq("drained_if_req", 32'(if_req), 32'h0);
    check_eq("drained_d_req", 32'(d_req), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
